// File: rtl/result_pack.sv
// result_pack: packs GROUP_NB-pixel result beats from the compute array into
// STR_RES_WIDTH stream words for the host. The frame length (in input beats)
// and the ReLU enable come from the cfg bus. The final word of every frame
// carries str_res_last, and any disagreement between the producer's
// result_last and the configured length raises a sticky err flag.
//
// Handshake rule for both buses: a transfer happens on a rising clk edge
// where valid and ready are both 1. Valid never waits for ready. A source
// holds its payload stable from the cycle valid rises until that transfer
// edge. This block holds str_res_bus and str_res_last stable while
// str_res_val is 1 and str_res_rdy is 0.
module result_pack #(
    parameter int                    CFG_DWIDTH    = 32,
    parameter int                    CFG_AWIDTH    = 5,
    parameter logic [CFG_AWIDTH-1:0] CFG_RES_ADDR  = 5'd12,
    parameter int                    STR_RES_WIDTH = 128,
    parameter int                    GROUP_NB      = 4,
    parameter int                    IMG_WIDTH     = 16,
    parameter int                    LEN_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    // configuration write port
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    // result beats from the compute array
    input  logic [GROUP_NB*IMG_WIDTH-1:0] result_bus,
    input  logic                          result_last,
    input  logic                          result_val,
    output logic                          result_rdy,
    // packed stream towards the host
    output logic [STR_RES_WIDTH-1:0]      str_res_bus,
    output logic                          str_res_last,
    output logic                          str_res_val,
    input  logic                          str_res_rdy,
    // sticky framing error
    output logic                          err,
    // current FSM state, for observation only
    output logic [1:0]                    state_o
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int BEAT_W   = GROUP_NB * IMG_WIDTH;           // bits per input beat
    localparam int R        = STR_RES_WIDTH / BEAT_W;         // beats per stream word
    localparam int IDX_W    = (R > 1) ? $clog2(R) : 1;        // lane slot index width
    localparam int RELU_BIT = 16;                             // relu_en position in cfg_data

    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;
    localparam logic [IDX_W-1:0]     IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]     IDX_MAX  = IDX_W'(R - 1);

    // ------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;   // waiting for a pending config
    localparam logic [1:0] S_RUN   = 2'd1;   // accepting beats of the frame
    localparam logic [1:0] S_DRAIN = 2'd2;   // last word waiting for the host

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]               state_q,      state_d;

    // Shadow config written from the cfg bus, copied to the active set in IDLE.
    logic [LEN_WIDTH-1:0]     shadow_len_q, shadow_len_d;
    logic                     shadow_relu_q, shadow_relu_d;
    logic                     cfg_pend_q,   cfg_pend_d;

    // Active config for the frame in progress.
    logic [LEN_WIDTH-1:0]     len_q,        len_d;
    logic                     relu_q,       relu_d;

    // Frame progress.
    logic [LEN_WIDTH-1:0]     beat_cnt_q,   beat_cnt_d;
    logic [IDX_W-1:0]         idx_q,        idx_d;
    logic [STR_RES_WIDTH-1:0] pack_q,       pack_d;

    // Output register.
    logic [STR_RES_WIDTH-1:0] out_bus_q,    out_bus_d;
    logic                     out_last_q,   out_last_d;
    logic                     out_val_q,    out_val_d;

    logic                     err_q,        err_d;

    // ------------------------------------------------------------------
    // Decoded events
    // ------------------------------------------------------------------
    logic                     cfg_hit;      // legal write addressed to this block
    logic                     load_cfg;     // shadow -> active this cycle
    logic                     beat_acc;     // input transfer this cycle
    logic                     is_beat_n;    // the beat on the bus is the frame's last
    logic                     word_done;    // accepted beat completes a stream word
    logic                     out_drain;    // output transfer this cycle
    logic [BEAT_W-1:0]        beat_proc;    // beat after optional ReLU
    logic [STR_RES_WIDTH-1:0] pack_merged;  // pack buffer with the new beat inserted

    // Only the length field and relu_en are decoded; the rest of the word is
    // reserved and tied into an intentionally unused net.
    logic [CFG_DWIDTH-1:0]    cfg_unused;
    assign cfg_unused = cfg_data;

    assign cfg_hit   = cfg_valid
                    && (cfg_addr == CFG_RES_ADDR)
                    && (cfg_data[LEN_WIDTH-1:0] != LEN_ZERO);
    assign load_cfg  = (state_q == S_IDLE) && cfg_pend_q;
    assign beat_acc  = result_val && result_rdy;
    assign is_beat_n = (beat_cnt_q == (len_q - LEN_ONE));
    assign word_done = beat_acc && ((idx_q == IDX_MAX) || is_beat_n);
    assign out_drain = out_val_q && str_res_rdy;

    // Beats are accepted only in RUN, and only when the output register can
    // take a completed word on the same edge (empty, or being drained).
    assign result_rdy = (state_q == S_RUN) && (!out_val_q || str_res_rdy);

    assign str_res_bus  = out_bus_q;
    assign str_res_last = out_last_q;
    assign str_res_val  = out_val_q;
    assign err          = err_q;
    assign state_o      = state_q;

    // Per-lane ReLU: negative signed pixels are replaced with zero.
    always_comb begin
        beat_proc = result_bus;
        for (int g = 0; g < GROUP_NB; g++) begin
            if (relu_q && result_bus[g*IMG_WIDTH + IMG_WIDTH - 1]) begin
                beat_proc[g*IMG_WIDTH +: IMG_WIDTH] = '0;
            end
        end
    end

    // Insert the processed beat at slot idx; untouched slots keep the buffer.
    always_comb begin
        pack_merged = pack_q;
        for (int k = 0; k < R; k++) begin
            if (idx_q == IDX_W'(k)) begin
                pack_merged[k*BEAT_W +: BEAT_W] = beat_proc;
            end
        end
    end

    // FSM next state: a frame ends on beat N, and the block goes idle once
    // the word carrying last has been taken by the host.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_cfg) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (beat_acc && is_beat_n) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_drain && out_last_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Config shadow and pending flag; a write in the same cycle as a load
    // re-arms the pending flag so that the newer config follows.
    always_comb begin
        shadow_len_d  = shadow_len_q;
        shadow_relu_d = shadow_relu_q;
        cfg_pend_d    = cfg_pend_q;
        len_d         = len_q;
        relu_d        = relu_q;
        if (load_cfg) begin
            len_d      = shadow_len_q;
            relu_d     = shadow_relu_q;
            cfg_pend_d = 1'b0;
        end
        if (cfg_hit) begin
            shadow_len_d  = cfg_data[LEN_WIDTH-1:0];
            shadow_relu_d = cfg_data[RELU_BIT];
            cfg_pend_d    = 1'b1;
        end
    end

    // Frame progress: beat counter, slot index and pack buffer.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        idx_d      = idx_q;
        pack_d     = pack_q;
        if (load_cfg) begin
            beat_cnt_d = '0;
            idx_d      = '0;
            pack_d     = '0;
        end else if (beat_acc) begin
            beat_cnt_d = beat_cnt_q + LEN_ONE;
            if (word_done) begin
                idx_d  = '0;
                pack_d = '0;
            end else begin
                idx_d  = idx_q + IDX_ONE;
                pack_d = pack_merged;
            end
        end
    end

    // Output register: a completed word loads directly, which may coincide
    // with the previous word being drained. Otherwise the word holds until
    // the host takes it.
    always_comb begin
        out_bus_d  = out_bus_q;
        out_last_d = out_last_q;
        out_val_d  = out_val_q;
        if (word_done) begin
            out_bus_d  = pack_merged;
            out_last_d = is_beat_n;
            out_val_d  = 1'b1;
        end else if (out_drain) begin
            out_last_d = 1'b0;
            out_val_d  = 1'b0;
        end
    end

    // Sticky framing error: result_last must appear on beat N and nowhere else.
    always_comb begin
        err_d = err_q;
        if (load_cfg) begin
            err_d = 1'b0;
        end else if (beat_acc && (result_last != is_beat_n)) begin
            err_d = 1'b1;
        end
    end

    // Control registers: FSM, config and frame progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            shadow_len_q  <= '0;
            shadow_relu_q <= 1'b0;
            cfg_pend_q    <= 1'b0;
            len_q         <= '0;
            relu_q        <= 1'b0;
            beat_cnt_q    <= '0;
            idx_q         <= '0;
            pack_q        <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_len_q  <= shadow_len_d;
            shadow_relu_q <= shadow_relu_d;
            cfg_pend_q    <= cfg_pend_d;
            len_q         <= len_d;
            relu_q        <= relu_d;
            beat_cnt_q    <= beat_cnt_d;
            idx_q         <= idx_d;
            pack_q        <= pack_d;
            err_q         <= err_d;
        end
    end

    // Output stream register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_bus_q  <= '0;
            out_last_q <= 1'b0;
            out_val_q  <= 1'b0;
        end else begin
            out_bus_q  <= out_bus_d;
            out_last_q <= out_last_d;
            out_val_q  <= out_val_d;
        end
    end

endmodule
